// File: rtl/fpu_sequencer.sv
// Request/response sequencer in front of the combinational FP ALU: holds operands,
// models per-opcode latency, captures result/flags, and keeps sticky flags and trap.
module fpu_sequencer #(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_MISC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_dest,
    output logic [3:0]  falu_opcode,
    output logic [31:0] falu_a,
    output logic [31:0] falu_b,
    input  logic [31:0] falu_result,
    input  logic [6:0]  falu_flags,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [6:0]  resp_flags,
    output logic [4:0]  resp_dest,
    output logic        busy,
    input  logic        flag_clear,
    input  logic [6:0]  trap_enable,
    output logic [6:0]  sticky_flags,
    output logic        trap
);
    localparam int unsigned CW  = 4;
    localparam int unsigned OPW = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned FW  = 7;
    localparam int unsigned TW  = 5;
    // Bit 0 (zero) is informational only: never sticky, never traps.
    localparam logic [FW-1:0] EXC_MASK = 7'h7E;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [OPW-1:0]  op_q;
    logic [DW-1:0]   a_q, b_q;
    logic [TW-1:0]   dest_q;
    logic            accept, capture, release_resp;

    function automatic logic [CW-1:0] lat_of(input logic [OPW-1:0] op);
        case (op)
            4'b0000, 4'b0001: return CW'(LAT_ADD);
            4'b0010:          return CW'(LAT_MUL);
            4'b0100, 4'b0101: return CW'(LAT_DIV);
            default:          return CW'(LAT_MISC);
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        capture      = 1'b0;
        release_resp = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: if (cnt == '0) begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (resp_ready) begin
                release_resp = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held request, latency countdown, response capture and flag bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            dest_q       <= '0;
            resp_valid   <= 1'b0;
            resp_result  <= '0;
            resp_flags   <= '0;
            resp_dest    <= '0;
            sticky_flags <= '0;
            trap         <= 1'b0;
        end else begin
            trap <= 1'b0;
            if (accept) begin
                op_q   <= req_opcode;
                a_q    <= req_a;
                b_q    <= req_b;
                dest_q <= req_dest;
                cnt    <= CW'(lat_of(req_opcode) - CW'(1));
            end else if (state == EXEC && cnt != '0) begin
                cnt <= CW'(cnt - CW'(1));
            end

            if (capture) begin
                resp_valid  <= 1'b1;
                resp_result <= falu_result;
                resp_flags  <= falu_flags;
                resp_dest   <= dest_q;
                trap        <= |(falu_flags & trap_enable & EXC_MASK);
            end else if (release_resp) begin
                resp_valid <= 1'b0;
            end

            // A coincident clear wipes history before this capture's flags are merged.
            if (capture)
                sticky_flags <= (flag_clear ? '0 : sticky_flags) | (falu_flags & EXC_MASK);
            else if (flag_clear)
                sticky_flags <= '0;
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign falu_opcode = op_q;
    assign falu_a      = a_q;
    assign falu_b      = b_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: directed scenarios followed by random
// transactions compared against a latency table and sticky/trap model.
module tb_fpu_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_dest;
    logic [3:0]  falu_opcode;
    logic [31:0] falu_a, falu_b;
    logic [31:0] falu_result;
    logic [6:0]  falu_flags;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [6:0]  resp_flags;
    logic [4:0]  resp_dest;
    logic        busy;
    logic        flag_clear;
    logic [6:0]  trap_enable;
    logic [6:0]  sticky_flags;
    logic        trap;

    int total = 0;
    int bad   = 0;
    int lat_tab [16];
    logic [6:0] exp_sticky;

    fpu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
        .falu_opcode(falu_opcode), .falu_a(falu_a), .falu_b(falu_b),
        .falu_result(falu_result), .falu_flags(falu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .resp_dest(resp_dest), .busy(busy),
        .flag_clear(flag_clear), .trap_enable(trap_enable),
        .sticky_flags(sticky_flags), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/response transaction; hold = cycles of response backpressure.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] dest, input logic [31:0] res, input logic [6:0] fl,
                           input logic [6:0] ten, input bit clr, input int hold, input bit keep_valid);
        int   n;
        int   exp_lat;
        logic e_trap;
        exp_lat = lat_tab[op];
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_opcode  = op;
        req_a       = a;
        req_b       = b;
        req_dest    = dest;
        falu_result = res;
        falu_flags  = fl;
        trap_enable = ten;
        tick();
        if (!keep_valid) req_valid = 1'b0;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_ready", 32'(req_ready), 32'd0);
        chk("falu_op", 32'(falu_opcode), 32'(op));
        chk("falu_a", falu_a, a);
        chk("falu_b", falu_b, b);
        n = 0;
        while (!resp_valid && n < 40) begin
            chk("exec_op", 32'(falu_opcode), 32'(op));
            n++;
            if (n == exp_lat && clr) flag_clear = 1'b1;
            tick();
            flag_clear = 1'b0;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        exp_sticky = (clr ? 7'h00 : exp_sticky) | (fl & 7'h7E);
        e_trap     = |(fl & ten & 7'h7E);
        falu_result = ~res;
        falu_flags  = ~fl;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_result", resp_result, res);
        chk("resp_flags", 32'(resp_flags), 32'(fl));
        chk("resp_dest", 32'(resp_dest), 32'(dest));
        chk("trap_first", 32'(trap), 32'(e_trap));
        chk("sticky", 32'(sticky_flags), 32'(exp_sticky));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_result", resp_result, res);
            chk("hold_dest", 32'(resp_dest), 32'(dest));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_trap", 32'(trap), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("rel_valid", 32'(resp_valid), 32'd0);
        chk("rel_trap", 32'(trap), 32'd0);
        chk("rel_ready", 32'(req_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lat_tab[i] = 1;
        lat_tab[0] = 2;
        lat_tab[1] = 2;
        lat_tab[2] = 4;
        lat_tab[4] = 10;
        lat_tab[5] = 10;
        exp_sticky  = 7'h00;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_opcode  = 4'h0;
        req_a       = 32'h0;
        req_b       = 32'h0;
        req_dest    = 5'h0;
        falu_result = 32'h0;
        falu_flags  = 7'h0;
        resp_ready  = 1'b0;
        flag_clear  = 1'b0;
        trap_enable = 7'h0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_falu_a", falu_a, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Add with nominal timing.
        run_txn(4'b0000, 32'h3FC00000, 32'h40100000, 5'd3, 32'h40700000, 7'h00, 7'h00, 1'b0, 0, 1'b0);
        // Divide by zero with DBZ trap enabled.
        run_txn(4'b0100, 32'h3F800000, 32'h00000000, 5'd7, 32'h7F800000, 7'h23, 7'h02, 1'b0, 0, 1'b0);
        // Backpressure with req_valid held high throughout.
        run_txn(4'b0010, 32'h40000000, 32'h40400000, 5'd12, 32'h40C00000, 7'h00, 7'h7F, 1'b0, 5, 1'b1);
        run_txn(4'b0001, 32'h40400000, 32'h3F800000, 5'd13, 32'h40000000, 7'h00, 7'h00, 1'b0, 0, 1'b0);

        // Standalone clear, then accumulate and clear-on-capture.
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        exp_sticky = 7'h00;
        chk("clr_sticky", 32'(sticky_flags), 32'd0);
        run_txn(4'b0010, 32'h1, 32'h2, 5'd1, 32'h3, 7'h10, 7'h00, 1'b0, 0, 1'b0);
        run_txn(4'b0000, 32'h4, 32'h5, 5'd2, 32'h6, 7'h40, 7'h00, 1'b0, 0, 1'b0);
        chk("acc_sticky", 32'(sticky_flags), 32'h50);
        run_txn(4'b0000, 32'h7, 32'h8, 5'd4, 32'h9, 7'h40, 7'h00, 1'b1, 0, 1'b0);
        chk("clr_cap_sticky", 32'(sticky_flags), 32'h40);

        // Reset two cycles into a divide.
        req_valid  = 1'b1;
        req_opcode = 4'b0100;
        req_a      = 32'hDEADBEEF;
        req_b      = 32'h12345678;
        req_dest   = 5'd9;
        falu_flags = 7'h7F;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_sticky = 7'h00;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_op", 32'(falu_opcode), 32'd0);
        chk("mid_rst_a", falu_a, 32'd0);
        chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_rst_valid", 32'(resp_valid), 32'd0);
        end
        run_txn(4'b0000, 32'h3F800000, 32'h3F800000, 5'd5, 32'h40000000, 7'h00, 7'h00, 1'b0, 0, 1'b0);

        // Undefined opcode passes straight through with misc latency.
        run_txn(4'b1010, 32'hCAFEF00D, 32'h0BADF00D, 5'd31, 32'h55AA55AA, 7'h5B, 7'h00, 1'b0, 1, 1'b0);

        // Random transactions.
        for (int t = 0; t < 40; t++) begin
            run_txn(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                    $urandom, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
